// File: rtl/matmul_stream_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : matmul_stream_ctrl
// Brief    : Serial valid/ready front/back end for a 4x4 combinational matmul.
// Revision : 1.0 - initial release
// ============================================================================
module matmul_stream_ctrl #(
  parameter int ELEM_W        = 3,
  parameter int RES_W         = 8,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [ELEM_W-1:0]   in_data,
  output logic [16*ELEM_W-1:0] mat_a,
  output logic [16*ELEM_W-1:0] mat_b,
  input  logic [16*RES_W-1:0] mat_res,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [RES_W-1:0]    out_data,
  output logic                out_last,
  output logic                busy
);

  localparam int         c_ELEMS       = 16;
  localparam logic [3:0] c_SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_LOAD   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_DRAIN  = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [4:0]            r_in_cnt;
  logic [3:0]            r_settle_cnt;
  logic [3:0]            r_out_cnt;
  logic [16*ELEM_W-1:0]  r_mat_a;
  logic [16*ELEM_W-1:0]  r_mat_b;
  logic [RES_W-1:0]      r_bank [c_ELEMS];
  logic                  w_in_fire;
  logic                  w_out_fire;
  logic                  w_capture;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_LOAD;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    busy        = 1'b0;
    w_capture   = 1'b0;
    case (r_state)
      ST_LOAD: begin
        in_ready = 1'b1;
        if (in_valid && (r_in_cnt == 5'd31)) w_state_nxt = ST_SETTLE;
      end
      ST_SETTLE: begin
        busy = 1'b1;
        if (r_settle_cnt == c_SETTLE_LAST) begin
          w_capture   = 1'b1;
          w_state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready && (r_out_cnt == 4'd15)) w_state_nxt = ST_LOAD;
      end
      default: w_state_nxt = ST_LOAD;
    endcase
  end

  assign w_in_fire  = in_valid & in_ready;
  assign w_out_fire = out_valid & out_ready;

  // Counters wrap naturally: 32 operands on a 5-bit count, 16 results on 4 bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_in_cnt     <= '0;
      r_settle_cnt <= '0;
      r_out_cnt    <= '0;
    end else begin
      if (w_in_fire)  r_in_cnt  <= r_in_cnt + 5'd1;
      if (w_out_fire) r_out_cnt <= r_out_cnt + 4'd1;
      if ((r_state == ST_SETTLE) && !w_capture) r_settle_cnt <= r_settle_cnt + 4'd1;
      else                                      r_settle_cnt <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mat_a <= '0;
      r_mat_b <= '0;
    end else if (w_in_fire) begin
      for (int k = 0; k < c_ELEMS; k++) begin
        if (r_in_cnt == 5'(k))      r_mat_a[k*ELEM_W +: ELEM_W] <= in_data;
        if (r_in_cnt == 5'(k + 16)) r_mat_b[k*ELEM_W +: ELEM_W] <= in_data;
      end
    end
  end

  // Bank is the only copy of the results seen by the drain; mat_res is ignored after capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < c_ELEMS; k++) r_bank[k] <= '0;
    end else if (w_capture) begin
      for (int k = 0; k < c_ELEMS; k++) r_bank[k] <= mat_res[k*RES_W +: RES_W];
    end
  end

  assign mat_a    = r_mat_a;
  assign mat_b    = r_mat_b;
  assign out_data = out_valid ? r_bank[r_out_cnt] : '0;
  assign out_last = out_valid && (r_out_cnt == 4'd15);

endmodule
`default_nettype wire

// File: tb/tb_matmul_stream_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_matmul_stream_ctrl
// Brief    : Table-driven bench for matmul_stream_ctrl with a matmul model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_matmul_stream_ctrl;

  localparam int ELEM_W        = 3;
  localparam int RES_W         = 8;
  localparam int SETTLE_CYCLES = 2;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 in_valid;
  logic                 in_ready;
  logic [ELEM_W-1:0]    in_data;
  logic [16*ELEM_W-1:0] mat_a;
  logic [16*ELEM_W-1:0] mat_b;
  logic [16*RES_W-1:0]  mat_res;
  logic                 out_valid;
  logic                 out_ready;
  logic [RES_W-1:0]     out_data;
  logic                 out_last;
  logic                 busy;
  logic [RES_W-1:0]     res_xor;
  logic [RES_W-1:0]     acc;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [16*ELEM_W-1:0] a;
    logic [16*ELEM_W-1:0] b;
    logic [16*RES_W-1:0]  exp;
    bit                   bursty;
    bit                   stall;
  } vec_t;

  vec_t vecs [4];

  matmul_stream_ctrl #(
    .ELEM_W(ELEM_W), .RES_W(RES_W), .SETTLE_CYCLES(SETTLE_CYCLES)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .mat_a(mat_a), .mat_b(mat_b), .mat_res(mat_res),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .busy(busy)
  );

  always #5 clk = ~clk;

  // Combinational multiplier array; res_xor perturbs it after capture.
  always_comb begin
    mat_res = '0;
    acc     = '0;
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        acc = '0;
        for (int k = 0; k < 4; k++)
          acc = acc + 8'(mat_a[(4*i+k)*ELEM_W +: ELEM_W]) * 8'(mat_b[(4*k+j)*ELEM_W +: ELEM_W]);
        mat_res[(4*i+j)*RES_W +: RES_W] = acc ^ res_xor;
      end
    end
  end

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Loads one vector, then drains stop_after results with full checking.
  task automatic run_txn(input int vi, input int stop_after);
    int  k;
    int  n;
    int  got;
    bit  seen;
    logic [3:0] pat;
    pat  = 4'b1001;
    k    = 0;
    n    = 0;
    got  = 0;
    seen = 1'b0;
    out_ready = 1'b0;
    while (k < 32 && n < 2000) begin
      @(negedge clk);
      n++;
      in_valid = vecs[vi].bursty ? 1'($urandom_range(0, 1)) : 1'b1;
      in_data  = (k < 16) ? vecs[vi].a[k*ELEM_W +: ELEM_W] : vecs[vi].b[(k-16)*ELEM_W +: ELEM_W];
      if (in_valid && in_ready) k++;
    end
    if (k < 32) begin
      chk($sformatf("v%0d load_count", vi), k, 32);
      return;
    end
    n = 0;
    while (got < stop_after && n < 200) begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        in_valid = vecs[vi].bursty;
        in_data  = 3'd5;
        chk($sformatf("v%0d mat_a", vi), mat_a, vecs[vi].a);
        chk($sformatf("v%0d mat_b", vi), mat_b, vecs[vi].b);
        chk($sformatf("v%0d settle_in_ready", vi), in_ready, 0);
        chk($sformatf("v%0d settle_busy", vi), busy, 1);
      end
      if (!seen) begin
        if (!out_valid) continue;
        seen = 1'b1;
        chk($sformatf("v%0d latency", vi), n, SETTLE_CYCLES + 1);
        res_xor = 8'h5A;
      end
      chk($sformatf("v%0d out_valid[%0d]", vi, got), out_valid, 1);
      chk($sformatf("v%0d out_data[%0d]", vi, got), out_data, vecs[vi].exp[got*RES_W +: RES_W]);
      chk($sformatf("v%0d out_last[%0d]", vi, got), out_last, (got == 15));
      chk($sformatf("v%0d drain_in_ready[%0d]", vi, got), in_ready, 0);
      out_ready = vecs[vi].stall ? pat[n%4] : 1'b1;
      if (out_ready) got++;
    end
    if (got < stop_after) begin
      chk($sformatf("v%0d drain_count", vi), got, stop_after);
      return;
    end
    if (stop_after == 16) begin
      @(negedge clk);
      out_ready = 1'b0;
      res_xor   = '0;
      chk($sformatf("v%0d post_in_ready", vi), in_ready, 1);
      chk($sformatf("v%0d post_out_valid", vi), out_valid, 0);
      chk($sformatf("v%0d post_busy", vi), busy, 0);
      chk($sformatf("v%0d post_mat_a", vi), mat_a, vecs[vi].a);
      in_valid = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    int c;
    for (int i = 0; i < 16; i++) begin
      r = i / 4;
      c = i % 4;
      vecs[0].a[i*ELEM_W +: ELEM_W] = 3'((r == c) ? 1 : 0);
      vecs[0].b[i*ELEM_W +: ELEM_W] = 3'(i % 8);
      vecs[0].exp[i*RES_W +: RES_W] = 8'(i % 8);
      vecs[1].a[i*ELEM_W +: ELEM_W] = 3'd7;
      vecs[1].b[i*ELEM_W +: ELEM_W] = 3'd7;
      vecs[1].exp[i*RES_W +: RES_W] = 8'd196;
      vecs[2].a[i*ELEM_W +: ELEM_W] = 3'd1;
      vecs[2].b[i*ELEM_W +: ELEM_W] = 3'd2;
      vecs[2].exp[i*RES_W +: RES_W] = 8'd8;
      vecs[3].a[i*ELEM_W +: ELEM_W] = 3'd1;
      vecs[3].b[i*ELEM_W +: ELEM_W] = 3'(i % 8);
      vecs[3].exp[i*RES_W +: RES_W] = 8'(8 + 4*c);
    end
    vecs[0].bursty = 0; vecs[0].stall = 0;
    vecs[1].bursty = 0; vecs[1].stall = 0;
    vecs[2].bursty = 1; vecs[2].stall = 0;
    vecs[3].bursty = 0; vecs[3].stall = 1;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    res_xor   = '0;
    #12;
    chk("rst in_ready", in_ready, 1);
    chk("rst out_valid", out_valid, 0);
    chk("rst out_last", out_last, 0);
    chk("rst out_data", out_data, 0);
    chk("rst busy", busy, 0);
    chk("rst mat_a", mat_a, 0);
    chk("rst mat_b", mat_b, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int v = 0; v < 4; v++) run_txn(v, 16);

    // Reset in the middle of a load
    begin
      int k;
      int n;
      k = 0;
      n = 0;
      while (k < 20 && n < 200) begin
        @(negedge clk);
        n++;
        in_valid = 1'b1;
        in_data  = (k < 16) ? vecs[1].a[k*ELEM_W +: ELEM_W] : vecs[1].b[(k-16)*ELEM_W +: ELEM_W];
        if (in_ready) k++;
      end
      @(negedge clk);
      in_valid = 1'b0;
      chk("midload pre mat_a", mat_a, vecs[1].a);
      #1 rst_n = 1'b0;
      #1;
      chk("midload mat_a", mat_a, 0);
      chk("midload mat_b", mat_b, 0);
      chk("midload in_ready", in_ready, 1);
      chk("midload busy", busy, 0);
      #1 rst_n = 1'b1;
    end
    run_txn(0, 16);

    // Reset in the middle of a drain
    run_txn(1, 5);
    @(negedge clk);
    out_ready = 1'b0;
    chk("middrain pre out_valid", out_valid, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("middrain out_valid", out_valid, 0);
    chk("middrain busy", busy, 0);
    chk("middrain out_last", out_last, 0);
    #1 rst_n = 1'b1;
    res_xor = '0;
    run_txn(0, 16);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
